traffic_fsm_moore: RTL and testbench

Moore-style controller for a two-road intersection: Academic road (lights LA) and Bravado road (lights LB). Each road keeps green while its traffic sensor is active. When the sensor goes idle, that road passes through a timed yellow phase, and the other road then turns green. Outputs decode the current state only. The block drives the lamp drivers directly and sits at the top level of the intersection design.

---
 rtl/traffic_fsm_moore.sv | 89 ++++++++
 tb/tb_traffic_fsm_moore.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/traffic_fsm_moore.sv
// Moore controller for a two-road intersection (Academic LA / Bravado LB) with timed yellow phases.
// Define ALL_RED_EN to insert an all-red clearance state after each yellow phase.
module traffic_fsm_moore #(
   parameter int YELLOW_CYCLES  = 5,
   parameter int ALL_RED_CYCLES = 2,
   parameter int TIMER_W        = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       TA,
   input  logic       TB,
   output logic [2:0] LA,
   output logic [2:0] LB
);

   localparam logic [2:0] S0 = 3'd0;
   localparam logic [2:0] S1 = 3'd1;
   localparam logic [2:0] S2 = 3'd2;
   localparam logic [2:0] S3 = 3'd3;
`ifdef ALL_RED_EN
   localparam logic [2:0] R1 = 3'd4;
   localparam logic [2:0] R3 = 3'd5;
   localparam logic [2:0] AFTER_S1 = R1;
   localparam logic [2:0] AFTER_S3 = R3;
`else
   localparam logic [2:0] AFTER_S1 = S2;
   localparam logic [2:0] AFTER_S3 = S0;
`endif

   localparam logic [2:0] GREEN  = 3'b001;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] RED    = 3'b100;

   logic [2:0]         state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               timer_done;

   // Final timer count of a timed state: yellow states use YELLOW_CYCLES, clearance states ALL_RED_CYCLES.
   function automatic logic [TIMER_W-1:0] dwell_last(input logic [2:0] st);
      if (st == S1 || st == S3) begin
         return TIMER_W'(YELLOW_CYCLES - 1);
      end
      return TIMER_W'(ALL_RED_CYCLES - 1);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d    = S0;
      timer_d    = '0;
      timer_done = (timer_q == dwell_last(state_q));
      case (state_q)
         S0:      state_d = TA ? S0 : S1;
         S1:      state_d = timer_done ? AFTER_S1 : S1;
         S2:      state_d = TB ? S2 : S3;
         S3:      state_d = timer_done ? AFTER_S3 : S3;
`ifdef ALL_RED_EN
         R1:      state_d = timer_done ? S2 : R1;
         R3:      state_d = timer_done ? S0 : R3;
`endif
         default: state_d = S0;
      endcase
      // Timer only runs while dwelling in a timed state; green states and every transition clear it.
      if (state_d == state_q && state_q != S0 && state_q != S2) begin
         timer_d = timer_q + 1'b1;
      end
   end

   always_comb begin
      LA = RED;
      LB = RED;
      case (state_q)
         S0:      LA = GREEN;
         S1:      LA = YELLOW;
         S2:      LB = GREEN;
         S3:      LB = YELLOW;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_fsm_moore.sv
// Self-checking bench for traffic_fsm_moore: table-driven phase sequence plus async-reset corner cases.
// Build with ALL_RED_EN defined to exercise the all-red clearance variant.
module tb_traffic_fsm_moore;

   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] RED = 3'b100;
`ifdef ALL_RED_EN
   localparam int RED_N = 2;
`else
   localparam int RED_N = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       TA = 1'b1;
   logic       TB = 1'b0;
   logic [2:0] LA, LB;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       ta;
      logic       tb;
      logic [2:0] la;
      logic [2:0] lb;
   } vec_t;

   vec_t vecs[$];

   traffic_fsm_moore #(
      .YELLOW_CYCLES (5),
      .ALL_RED_CYCLES(2),
      .TIMER_W       (8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .TA   (TA),
      .TB   (TB),
      .LA   (LA),
      .LB   (LB)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [2:0] exp_la, input logic [2:0] exp_lb);
      checks++;
      if (LA !== exp_la || LB !== exp_lb) begin
         errors++;
         $display("FAIL %s: got LA=%b LB=%b, expected LA=%b LB=%b at t=%0t",
                  nm, LA, LB, exp_la, exp_lb, $time);
      end
   endtask

   task automatic chk_safe(input string nm);
      checks++;
      if (LA !== RED && LB !== RED) begin
         errors++;
         $display("FAIL %s: got LA=%b LB=%b, required at least one RED", nm, LA, LB);
      end
   endtask

   task automatic add(input logic ta, input logic tb, input logic [2:0] la, input logic [2:0] lb);
      vec_t v;
      v.ta = ta;
      v.tb = tb;
      v.la = la;
      v.lb = lb;
      vecs.push_back(v);
   endtask

   task automatic add_red(input logic ta, input logic tb);
      for (int i = 0; i < RED_N; i++) add(ta, tb, RED, RED);
   endtask

   initial begin
      // Academic holds green while TA=1
      for (int i = 0; i < 10; i++) add(1'b1, 1'b0, GRN, RED);
      // TA drops: 5 yellow cycles, inputs ignored while yellow
      add(1'b0, 1'b1, YEL, RED);
      add(1'b1, 1'b1, YEL, RED);
      add(1'b0, 1'b0, YEL, RED);
      add(1'b1, 1'b0, YEL, RED);
      add(1'b0, 1'b1, YEL, RED);
      add_red(1'b0, 1'b1);
      add(1'b0, 1'b1, RED, GRN);
      // Both sensors active: Bravado keeps green
      for (int i = 0; i < 9; i++) add(1'b1, 1'b1, RED, GRN);
      // Both idle: continuous alternation, one-cycle greens
      for (int i = 0; i < 5; i++) add(1'b0, 1'b0, RED, YEL);
      add_red(1'b0, 1'b0);
      add(1'b0, 1'b0, GRN, RED);
      for (int i = 0; i < 5; i++) add(1'b0, 1'b0, YEL, RED);
      add_red(1'b0, 1'b0);
      add(1'b0, 1'b0, RED, GRN);
      for (int i = 0; i < 5; i++) add(1'b0, 1'b0, RED, YEL);
      add_red(1'b1, 1'b0);
      add(1'b1, 1'b0, GRN, RED);
      add(1'b1, 1'b0, GRN, RED);

      // Async reset before any clock edge
      #2 reset = 1'b0;
      #1 chk("reset_immediate", GRN, RED);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("reset_held", GRN, RED);
      end
      reset = 1'b1;

      foreach (vecs[i]) begin
         TA = vecs[i].ta;
         TB = vecs[i].tb;
         tick();
         chk($sformatf("vec%0d", i), vecs[i].la, vecs[i].lb);
         chk_safe($sformatf("safe%0d", i));
      end

      // Reset asserted between edges during the third yellow cycle
      TA = 1'b0;
      tick();
      chk("mid_y1", YEL, RED);
      TA = 1'b1;
      tick();
      chk("mid_y2", YEL, RED);
      tick();
      chk("mid_y3", YEL, RED);
      #3 reset = 1'b0;
      #1 chk("mid_reset_immediate", GRN, RED);
      tick();
      chk("mid_reset_held", GRN, RED);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_reset_stay_s0", GRN, RED);
      end

      // Full yellow phase after reset recovery
      TA = 1'b0;
      TB = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post_reset_yellow", YEL, RED);
      end
      for (int i = 0; i < RED_N; i++) begin
         tick();
         chk("post_reset_allred", RED, RED);
      end
      tick();
      chk("post_reset_bravado", RED, GRN);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
